// File: rtl/apb_mem_master.sv
// APB requester for the 16x8 APB memory slave.
// Commands arrive on a valid/ready port, wait in a small FIFO, and are replayed
// as APB SETUP/ACCESS transfers. Each command produces exactly one response,
// either a normal completion or a timeout abort when PREADY never arrives.
module apb_mem_master #(
    parameter int ADDR_W     = 4,
    parameter int DATA_W     = 8,
    parameter int FIFO_DEPTH = 4,
    parameter int TIMEOUT    = 15
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    output logic              rsp_write,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              busy,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [ADDR_W-1:0] PADDR,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    localparam int TMO_W = $clog2(TIMEOUT + 1);

    typedef struct packed {
        logic              write;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SETUP,
        S_ACCESS
    } state_t;

    cmd_t              fifo_mem_q [FIFO_DEPTH];
    cmd_t              head;
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              fifo_full, fifo_empty;
    logic              push, pop;

    state_t            state_q, state_d;
    logic [TMO_W-1:0]  tmo_q, tmo_d, tmo_inc;
    logic              load_next;
    logic              done;

    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_write_q, rsp_write_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;

    // Ready depends only on the registered count, so there is no path from the pop.
    assign fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    assign fifo_empty = (count_q == '0);
    assign cmd_ready  = ~fifo_full;
    assign push       = cmd_valid & ~fifo_full;
    assign head       = fifo_mem_q[rd_ptr_q];
    assign busy       = ~fifo_empty | (state_q != S_IDLE);
    assign tmo_inc    = tmo_q + 1'b1;

    // Command storage needs no reset: the pointers decide which entries are live.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem_q[wr_ptr_q] <= {cmd_write, cmd_addr, cmd_wdata};
        end
    end

    // FIFO pointer and occupancy update; a simultaneous push and pop keeps the count.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
        if (push && !pop) begin
            count_d = count_q + 1'b1;
        end else if (!push && pop) begin
            count_d = count_q - 1'b1;
        end
    end

    // Transfer sequencer: next state, APB request fields, response and timeout.
    always_comb begin
        state_d     = state_q;
        tmo_d       = tmo_q;
        pwrite_d    = pwrite_q;
        paddr_d     = paddr_q;
        pwdata_d    = pwdata_q;
        rsp_valid_d = 1'b0;
        rsp_err_d   = 1'b0;
        rsp_write_d = rsp_write_q;
        rsp_rdata_d = rsp_rdata_q;
        load_next   = 1'b0;
        done        = 1'b0;
        pop         = 1'b0;

        case (state_q)
            S_IDLE: begin
                load_next = ~fifo_empty;
            end
            S_SETUP: begin
                tmo_d   = '0;
                state_d = S_ACCESS;
            end
            S_ACCESS: begin
                if (PREADY) begin
                    done        = 1'b1;
                    rsp_valid_d = 1'b1;
                    rsp_write_d = pwrite_q;
                    if (!pwrite_q) begin
                        rsp_rdata_d = PRDATA;
                    end
                end else begin
                    tmo_d = tmo_inc;
                    if (tmo_inc == TMO_W'(TIMEOUT)) begin
                        done        = 1'b1;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_write_d = pwrite_q;
                    end
                end
                if (done) begin
                    if (fifo_empty) begin
                        state_d = S_IDLE;
                    end else begin
                        load_next = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (load_next) begin
            pop      = 1'b1;
            pwrite_d = head.write;
            paddr_d  = head.addr;
            pwdata_d = head.wdata;
            state_d  = S_SETUP;
        end

        psel_d    = (state_d != S_IDLE);
        penable_d = (state_d == S_ACCESS);
    end

    // State, queue bookkeeping and all registered outputs; reset abandons any work.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= S_IDLE;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            tmo_q       <= '0;
            psel_q      <= 1'b0;
            penable_q   <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_write_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            tmo_q       <= tmo_d;
            psel_q      <= psel_d;
            penable_q   <= penable_d;
            pwrite_q    <= pwrite_d;
            paddr_q     <= paddr_d;
            pwdata_q    <= pwdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_write_q <= rsp_write_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign PSEL      = psel_q;
    assign PENABLE   = penable_q;
    assign PWRITE    = pwrite_q;
    assign PADDR     = paddr_q;
    assign PWDATA    = pwdata_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_write = rsp_write_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;

endmodule

// File: tb/tb_apb_mem_master.sv
// Bench for apb_mem_master: drives it against a behavioural 16x8 APB memory
// slave (writes ready at once, reads with one wait state, optional hang).
module tb_apb_mem_master;

    logic       clk;
    logic       rstn;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [3:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic       rsp_write;
    logic [7:0] rsp_rdata;
    logic       rsp_err;
    logic       busy;
    logic       PSEL;
    logic       PENABLE;
    logic       PWRITE;
    logic [3:0] PADDR;
    logic [7:0] PWDATA;
    logic [7:0] PRDATA;
    logic       PREADY;

    apb_mem_master #(
        .ADDR_W(4), .DATA_W(8), .FIFO_DEPTH(4), .TIMEOUT(15)
    ) dut (
        .clk(clk), .rstn(rstn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy),
        .PSEL(PSEL), .PENABLE(PENABLE), .PWRITE(PWRITE), .PADDR(PADDR),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Slave model: memory, one read wait state, and a hang switch.
    logic [7:0] slv_mem [16];
    logic       rd_wait_q;
    logic       hang;
    logic       slv_clear;

    assign PREADY = PSEL & PENABLE & ~hang & (PWRITE | rd_wait_q);
    assign PRDATA = slv_mem[PADDR];

    // Read wait-state tracker for the slave model.
    always @(posedge clk or negedge rstn) begin
        if (!rstn) rd_wait_q <= 1'b0;
        else       rd_wait_q <= PSEL & PENABLE & ~PWRITE & ~PREADY;
    end

    // Slave memory write port (cleared during the initial reset).
    always @(posedge clk) begin
        if (slv_clear) begin
            for (int i = 0; i < 16; i++) slv_mem[i] <= 8'h00;
        end else if (PSEL && PENABLE && PREADY && PWRITE) begin
            slv_mem[PADDR] <= PWDATA;
        end
    end

    // Response monitor: logs every response pulse mid-cycle.
    typedef struct {
        logic       write;
        logic [7:0] rdata;
        logic       err;
    } rsp_t;
    rsp_t rsp_q [$];

    always @(negedge clk) begin
        if (rsp_valid) rsp_q.push_back('{rsp_write, rsp_rdata, rsp_err});
    end

    typedef struct {
        logic psel;
        logic penable;
        logic rsp_valid;
    } cyc_t;

    typedef struct {
        logic       write;
        logic [3:0] addr;
        logic [7:0] wdata;
        logic [7:0] exp_rdata;
    } cmd_vec_t;

    int n_checks = 0;
    int n_passed = 0;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_passed++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Presents one command for one edge; the caller ensures cmd_ready is high.
    task automatic apply_stimulus(input logic w, input logic [3:0] a, input logic [7:0] d);
        cmd_valid = 1'b1;
        cmd_write = w;
        cmd_addr  = a;
        cmd_wdata = d;
        step();
        cmd_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int n, input int budget);
        int k;
        k = 0;
        while (rsp_q.size() < n && k < budget) begin
            step();
            k++;
        end
        if (rsp_q.size() < n) check_output("rsp_wait_expired", rsp_q.size(), n);
    endtask

    task automatic check_rsp_list(input string tag, input int base, input cmd_vec_t v [], input int n);
        for (int i = 0; i < n; i++) begin
            if (rsp_q.size() > base + i) begin
                check_output($sformatf("%s_rsp%0d_write", tag, i), rsp_q[base+i].write, v[i].write);
                check_output($sformatf("%s_rsp%0d_err", tag, i), rsp_q[base+i].err, 1'b0);
                if (!v[i].write)
                    check_output($sformatf("%s_rsp%0d_rdata", tag, i), rsp_q[base+i].rdata, v[i].exp_rdata);
            end else begin
                check_output($sformatf("%s_rsp%0d_missing", tag, i), 0, 1);
            end
        end
    endtask

    initial begin
        cyc_t     wr_seq [5];
        cyc_t     rd_seq [6];
        cmd_vec_t five   [];
        cmd_vec_t simul  [];
        int       base;
        int       idle;
        int       acc;

        wr_seq = '{'{1'b0,1'b0,1'b0}, '{1'b1,1'b0,1'b0}, '{1'b1,1'b1,1'b0},
                   '{1'b0,1'b0,1'b1}, '{1'b0,1'b0,1'b0}};
        rd_seq = '{'{1'b0,1'b0,1'b0}, '{1'b1,1'b0,1'b0}, '{1'b1,1'b1,1'b0},
                   '{1'b1,1'b1,1'b0}, '{1'b0,1'b0,1'b1}, '{1'b0,1'b0,1'b0}};
        five   = '{'{1'b1,4'd5,8'h11,8'h00}, '{1'b1,4'd6,8'h22,8'h00}, '{1'b0,4'd5,8'h00,8'h11},
                   '{1'b1,4'd5,8'h33,8'h00}, '{1'b0,4'd5,8'h00,8'h33}};
        simul  = '{'{1'b1,4'd11,8'hA1,8'h00}, '{1'b0,4'd11,8'h00,8'hA1}, '{1'b1,4'd12,8'hB2,8'h00},
                   '{1'b0,4'd12,8'h00,8'hB2}, '{1'b0,4'd11,8'h00,8'hA1}, '{1'b0,4'd12,8'h00,8'hB2}};

        rstn = 1'b0; cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0;
        hang = 1'b0; slv_clear = 1'b1;
        repeat (3) @(posedge clk);
        #1;

        // Reset state
        check_output("rst_psel", PSEL, 1'b0);
        check_output("rst_penable", PENABLE, 1'b0);
        check_output("rst_pwrite", PWRITE, 1'b0);
        check_output("rst_paddr", PADDR, 4'h0);
        check_output("rst_pwdata", PWDATA, 8'h00);
        check_output("rst_rsp_valid", rsp_valid, 1'b0);
        check_output("rst_rsp_rdata", rsp_rdata, 8'h00);
        check_output("rst_rsp_err", rsp_err, 1'b0);
        check_output("rst_cmd_ready", cmd_ready, 1'b1);
        check_output("rst_busy", busy, 1'b0);
        slv_clear = 1'b0;
        rstn = 1'b1;
        step();

        // Single write, cycle by cycle from the accept edge
        apply_stimulus(1'b1, 4'd3, 8'hA5);
        for (int i = 0; i < 5; i++) begin
            check_output($sformatf("wr_c%0d_psel", i), PSEL, wr_seq[i].psel);
            check_output($sformatf("wr_c%0d_penable", i), PENABLE, wr_seq[i].penable);
            check_output($sformatf("wr_c%0d_rsp_valid", i), rsp_valid, wr_seq[i].rsp_valid);
            if (i == 1) begin
                check_output("wr_pwrite", PWRITE, 1'b1);
                check_output("wr_paddr", PADDR, 4'd3);
                check_output("wr_pwdata", PWDATA, 8'hA5);
            end
            if (i == 3) begin
                check_output("wr_rsp_write", rsp_write, 1'b1);
                check_output("wr_rsp_err", rsp_err, 1'b0);
            end
            step();
        end

        // Single read with one slave wait state
        apply_stimulus(1'b0, 4'd3, 8'h00);
        for (int i = 0; i < 6; i++) begin
            check_output($sformatf("rd_c%0d_psel", i), PSEL, rd_seq[i].psel);
            check_output($sformatf("rd_c%0d_penable", i), PENABLE, rd_seq[i].penable);
            check_output($sformatf("rd_c%0d_rsp_valid", i), rsp_valid, rd_seq[i].rsp_valid);
            if (i == 4) begin
                check_output("rd_rsp_rdata", rsp_rdata, 8'hA5);
                check_output("rd_rsp_err", rsp_err, 1'b0);
                check_output("rd_rsp_write", rsp_write, 1'b0);
            end
            step();
        end
        check_output("rd_busy_end", busy, 1'b0);

        // Five back-to-back commands against a stalled first transfer
        base = rsp_q.size();
        hang = 1'b1;
        for (int i = 0; i < 5; i++) apply_stimulus(five[i].write, five[i].addr, five[i].wdata);
        check_output("b2b_cmd_ready_full", cmd_ready, 1'b0);
        check_output("b2b_busy", busy, 1'b1);
        hang = 1'b0;
        idle = 0;
        for (int k = 0; k < 60 && (rsp_q.size() - base) < 5; k++) begin
            step();
            if (!PSEL && (rsp_q.size() - base) < 4) idle++;
        end
        check_output("b2b_idle_gaps", idle, 0);
        wait_rsp(base + 5, 10);
        check_rsp_list("b2b", base, five, 5);

        // Timeout abort followed by a normal write
        step();
        base = rsp_q.size();
        hang = 1'b1;
        apply_stimulus(1'b0, 4'd5, 8'h00);
        apply_stimulus(1'b1, 4'd7, 8'h77);
        acc = 0;
        for (int k = 0; k < 40; k++) begin
            step();
            if (rsp_valid) break;
            if (PSEL && PENABLE) acc++;
        end
        hang = 1'b0;
        check_output("tmo_access_cycles", acc, 15);
        check_output("tmo_rsp_valid", rsp_valid, 1'b1);
        check_output("tmo_rsp_err", rsp_err, 1'b1);
        check_output("tmo_rsp_write", rsp_write, 1'b0);
        check_output("tmo_rsp_rdata_held", rsp_rdata, 8'h33);
        wait_rsp(base + 2, 20);
        if (rsp_q.size() >= base + 2) begin
            check_output("tmo_next_err", rsp_q[base+1].err, 1'b0);
            check_output("tmo_next_write", rsp_q[base+1].write, 1'b1);
        end
        check_output("tmo_next_mem", slv_mem[7], 8'h77);

        // Simultaneous push and pop with three queued entries
        step();
        base = rsp_q.size();
        hang = 1'b1;
        for (int i = 0; i < 4; i++) apply_stimulus(simul[i].write, simul[i].addr, simul[i].wdata);
        check_output("sim_ready_at_3", cmd_ready, 1'b1);
        hang = 1'b0;
        apply_stimulus(simul[4].write, simul[4].addr, simul[4].wdata);
        check_output("sim_rsp_at_push", rsp_valid, 1'b1);
        check_output("sim_ready_still_3", cmd_ready, 1'b1);
        apply_stimulus(simul[5].write, simul[5].addr, simul[5].wdata);
        check_output("sim_ready_full_4", cmd_ready, 1'b0);
        wait_rsp(base + 6, 80);
        repeat (10) step();
        check_output("sim_rsp_count", rsp_q.size() - base, 6);
        check_rsp_list("sim", base, simul, 6);

        // Reset during a read ACCESS with two commands queued
        step();
        apply_stimulus(1'b0, 4'd5, 8'h00);
        apply_stimulus(1'b1, 4'd10, 8'hDD);
        apply_stimulus(1'b1, 4'd10, 8'hEE);
        check_output("rstmid_in_access", PSEL && PENABLE, 1'b1);
        #1;
        rstn = 1'b0;
        #1;
        check_output("rstmid_psel", PSEL, 1'b0);
        check_output("rstmid_penable", PENABLE, 1'b0);
        check_output("rstmid_busy", busy, 1'b0);
        base = rsp_q.size();
        step();
        step();
        rstn = 1'b1;
        check_output("rstmid_cmd_ready", cmd_ready, 1'b1);
        repeat (8) step();
        check_output("rstmid_no_rsp", rsp_q.size() - base, 0);
        check_output("rstmid_queued_lost", slv_mem[10], 8'h00);
        apply_stimulus(1'b1, 4'd9, 8'h99);
        wait_rsp(base + 1, 20);
        apply_stimulus(1'b0, 4'd9, 8'h00);
        wait_rsp(base + 2, 20);
        if (rsp_q.size() >= base + 2) begin
            check_output("rstmid_wr_write", rsp_q[base].write, 1'b1);
            check_output("rstmid_wr_err", rsp_q[base].err, 1'b0);
            check_output("rstmid_rd_rdata", rsp_q[base+1].rdata, 8'h99);
        end

        $display("%0d/%0d checks passed", n_passed, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
